// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_pkg;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int NUM_REQ = 2;
    localparam int CNT_W   = 16;

    // Writes to this register are accepted but never reach the register file.
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    // Identifies which requester won the most recent transfer.
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, register-file write and status bundle.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              req0_valid_i;
    logic [ADDR_W-1:0] req0_addr_i;
    logic [DATA_W-1:0] req0_data_i;
    logic              req0_ready_o;
    logic              req1_valid_i;
    logic [ADDR_W-1:0] req1_addr_i;
    logic [DATA_W-1:0] req1_data_i;
    logic              req1_ready_o;
    logic              freeze_i;
    logic              rf_we_o;
    logic [ADDR_W-1:0] rf_addr_o;
    logic [DATA_W-1:0] rf_data_o;
    logic [ADDR_W-1:0] pend_addr_i;
    logic              pend_hit_o;
    logic [15:0]       grant_cnt0_o;
    logic [15:0]       grant_cnt1_o;

    modport slave (
        input  req0_valid_i, req0_addr_i, req0_data_i,
        input  req1_valid_i, req1_addr_i, req1_data_i,
        input  freeze_i, pend_addr_i,
        output req0_ready_o, req1_ready_o,
        output rf_we_o, rf_addr_o, rf_data_o, pend_hit_o,
        output grant_cnt0_o, grant_cnt1_o
    );

    modport master (
        output req0_valid_i, req0_addr_i, req0_data_i,
        output req1_valid_i, req1_addr_i, req1_data_i,
        output freeze_i, pend_addr_i,
        input  req0_ready_o, req1_ready_o,
        input  rf_we_o, rf_addr_o, rf_data_o, pend_hit_o,
        input  grant_cnt0_o, grant_cnt1_o
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, and on a tie
// the requester that did not win last time is chosen.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_block,
    input  req_id_e    i_last,
    output logic [1:0] o_grant
);

    // Grant decode; i_block suppresses everything (freeze or reset).
    always_comb begin
        o_grant = 2'b00;
        if (!i_block) begin
            if (&i_valid) begin
                o_grant = (i_last == REQ1) ? 2'b01 : 2'b10;
            end else begin
                o_grant = i_valid;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto a single register-file write
// port, with one-cycle write latency, a hazard probe on the in-flight
// write and per-requester transfer counters.
module regfile_wb_arbiter #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    regfile_wb_arbiter_if.slave  bus
);
    import regfile_pkg::*;

    logic [NUM_REQ-1:0] w_valid;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_block;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_data;

    req_id_e            r_last;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic [CNT_W-1:0]   r_cnt0;
    logic [CNT_W-1:0]   r_cnt1;

    assign w_valid = {bus.req1_valid_i, bus.req0_valid_i};
    // Reset blocks grants the same way freeze does so nothing transfers.
    assign w_block = bus.freeze_i | rst_i;

    rr_arb2 u_arb (
        .i_valid (w_valid),
        .i_block (w_block),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    assign w_addr = w_grant[1] ? bus.req1_addr_i : bus.req0_addr_i;
    assign w_data = w_grant[1] ? bus.req1_data_i : bus.req0_data_i;

    // Register the winning request; zero-register writes are counted but dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last <= REQ1;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            r_we <= 1'b0;
            if (|w_grant) begin
                r_addr <= w_addr;
                r_data <= w_data;
                r_we   <= (w_addr != ADDR_W'(ZERO_REG));
                r_last <= w_grant[1] ? REQ1 : REQ0;
            end
            if (w_grant[0]) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_grant[1]) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign bus.req0_ready_o = w_grant[0];
    assign bus.req1_ready_o = w_grant[1];
    assign bus.rf_we_o      = r_we;
    assign bus.rf_addr_o    = r_addr;
    assign bus.rf_data_o    = r_data;
    assign bus.pend_hit_o   = r_we && (bus.pend_addr_i == r_addr);
    assign bus.grant_cnt0_o = r_cnt0;
    assign bus.grant_cnt1_o = r_cnt1;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: the stimulus side predicts each cycle's register-file
// view from the arbitration rules and queues it; a monitor pops and compares.
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [15:0] c0;
        logic [15:0] c1;
        logic        hit;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Reference state: what the register-file port and counters should show.
    logic        m_we   = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [15:0] m_c0   = '0;
    logic [15:0] m_c1   = '0;
    int          m_last = 1;   // requester that won the most recent transfer
    logic        g0, g1;       // model grants of the latest cycle

    // One clock of stimulus: drive, check readies, predict next-cycle outputs.
    task automatic cycle(input logic r, input logic fz,
                         input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic [4:0] pa);
        exp_t e;
        @(negedge clk);
        rst = r;
        bus.freeze_i = fz;
        bus.req0_valid_i = v0; bus.req0_addr_i = a0; bus.req0_data_i = d0;
        bus.req1_valid_i = v1; bus.req1_addr_i = a1; bus.req1_data_i = d1;
        bus.pend_addr_i = pa;
        #1;
        g0 = 1'b0; g1 = 1'b0;
        if (!r && !fz) begin
            if (v0 && v1) begin
                if (m_last == 1) g0 = 1'b1; else g1 = 1'b1;
            end else begin
                g0 = v0; g1 = v1;
            end
        end
        total++;
        if (bus.req0_ready_o !== g0 || bus.req1_ready_o !== g1) begin
            bad++;
            $display("FAIL ready: got r0=%b r1=%b want r0=%b r1=%b (t=%0t)",
                     bus.req0_ready_o, bus.req1_ready_o, g0, g1, $time);
        end
        if (r) begin
            m_we = 0; m_addr = 0; m_data = 0; m_c0 = 0; m_c1 = 0; m_last = 1;
        end else if (g0) begin
            m_we = (a0 != 0); m_addr = a0; m_data = d0; m_c0 = m_c0 + 16'd1; m_last = 0;
        end else if (g1) begin
            m_we = (a1 != 0); m_addr = a1; m_data = d1; m_c1 = m_c1 + 16'd1; m_last = 1;
        end else begin
            m_we = 0;
        end
        e.we = m_we; e.addr = m_addr; e.data = m_data;
        e.c0 = m_c0; e.c1 = m_c1;
        e.hit = m_we && (pa == m_addr);
        exp_q.push_back(e);
    endtask

    // Monitor: after every edge compare the registered outputs with the queue.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (bus.rf_we_o !== e.we || bus.rf_addr_o !== e.addr || bus.rf_data_o !== e.data ||
                bus.grant_cnt0_o !== e.c0 || bus.grant_cnt1_o !== e.c1 || bus.pend_hit_o !== e.hit) begin
                bad++;
                $display("FAIL rf_port: got we=%b a=%0d d=%h c0=%h c1=%h hit=%b want we=%b a=%0d d=%h c0=%h c1=%h hit=%b (t=%0t)",
                         bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o, bus.grant_cnt0_o,
                         bus.grant_cnt1_o, bus.pend_hit_o,
                         e.we, e.addr, e.data, e.c0, e.c1, e.hit, $time);
            end
        end
    end

    logic        p0, p1;
    logic [4:0]  pa0, pa1, qa;
    logic [31:0] pd0, pd1;

    initial begin
        bus.freeze_i = 0; bus.pend_addr_i = 0;
        bus.req0_valid_i = 0; bus.req0_addr_i = 0; bus.req0_data_i = 0;
        bus.req1_valid_i = 0; bus.req1_addr_i = 0; bus.req1_data_i = 0;

        // Reset, then a single ALU write to r3.
        cycle(1, 0, 1, 5'd7, 32'h77, 1, 5'd8, 32'h88, 5'd0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 5'd0);
        cycle(0, 0, 1, 5'd3, 32'h11, 0, 0, 0, 5'd3);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd3);

        // Contention: both requesters hold addr 5/6; grants must alternate.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 5'd0);
        for (int i = 0; i < 4; i++)
            cycle(0, 0, 1, 5'd5, 32'hA5A5_0005, 1, 5'd6, 32'h5A5A_0006, 5'd5);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd6);

        // Load writeback to r0: accepted, counted, not written.
        cycle(0, 0, 0, 0, 0, 1, 5'd0, 32'hDEAD, 5'd0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd0);

        // Freeze with both valid, then release: pointer untouched by freeze.
        cycle(0, 0, 0, 0, 0, 1, 5'd4, 32'h44, 5'd4);
        for (int i = 0; i < 3; i++)
            cycle(0, 1, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 5'd1);
        cycle(0, 0, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 5'd1);
        cycle(0, 0, 0, 0, 0, 1, 5'd2, 32'h2, 5'd2);

        // Hazard probe against an in-flight write to r9.
        cycle(0, 0, 1, 5'd9, 32'h99, 0, 0, 0, 5'd9);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd9);
        cycle(0, 0, 1, 5'd9, 32'h98, 0, 0, 0, 5'd8);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd8);

        // Randomized traffic with requesters holding until accepted.
        p0 = 0; p1 = 0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1; pa0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom); pd0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1; pa1 = ($urandom_range(0, 3) == 0) ? pa0 : 5'($urandom); pd1 = $urandom;
            end
            qa = ($urandom_range(0, 1) == 0) ? pa0 : 5'($urandom);
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
                  p0, pa0, pd0, p1, pa1, pd1, qa);
            if (g0) p0 = 0;
            if (g1) p1 = 0;
        end

        // Counter wrap: 65535 transfers reach 0xFFFF, one more wraps to 0.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 5'd0);
        for (int i = 0; i < 65535; i++)
            cycle(0, 0, 1, 5'($urandom), $urandom, 0, 0, 0, 5'($urandom));
        cycle(0, 0, 1, 5'd12, 32'hC0FFEE, 0, 0, 0, 5'd12);
        cycle(0, 0, 1, 5'd13, 32'hBEEF, 1, 5'd14, 32'hF00D, 5'd13);
        // Reset mid-burst: in-flight request discarded, outputs cleared.
        cycle(1, 0, 1, 5'd13, 32'hBEEF, 1, 5'd14, 32'hF00D, 5'd13);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd0);

        @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
